axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_slave.sv | 278 +++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//   Simple AXI-style slave in front of a 64-bit wide on-chip SRAM.
//   One outstanding read and one outstanding write at a time; the read and
//   write channels run independently and may overlap.
//
//   Handshake rule (all channels): a transfer happens on the rising edge where
//   both valid and ready are 1. A valid, once raised by this block, stays high
//   with its payload unchanged until that edge.
//
//   Optional feature: define SRAM_RAND_DELAY_EN to add a pseudo-random 0..3
//   cycles (from an 8-bit LFSR) to every transaction's wait time.
//
//   Parameters
//     DEPTH_LOG2  memory holds 2**DEPTH_LOG2 64-bit words
//     BASE_ADDR   byte address of word 0
//     RD_LAT      read wait cycles (0..15)
//     WR_LAT      write wait cycles (0..15)
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     arvalid/araddr/arready        read address channel
//     rvalid/rresp/rdata/rready     read data channel
//     awvalid/awaddr/awready        write address channel
//     wvalid/wdata/wstrb/wready     write data channel (accepted with AW)
//     bvalid/bresp/bready           write response channel
//     rd_state, wr_state            debug view of the read / write FSM state
//                                   (IDLE=0, WAIT=1, RESP=2)
// -----------------------------------------------------------------------------
module axi_sram_slave #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LAT     = 2,
  parameter int          WR_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  // read address / data
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [1:0]  rresp,
  output logic [63:0] rdata,
  input  logic        rready,
  // write address / data / response
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  output logic [1:0]  bresp,
  input  logic        bready,
  // debug
  output logic [1:0]  rd_state,
  output logic [1:0]  wr_state
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  // Byte span of the memory; one bit wider so a 4 GiB span cannot wrap.
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 3;
  localparam logic [4:0]  RD_BASE = 5'(RD_LAT);
  localparam logic [4:0]  WR_BASE = 5'(WR_LAT);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [63:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode. The offset is taken over the full 32 bits so addresses
  // below BASE_ADDR wrap to huge values and fall out of range.
  // ---------------------------------------------------------------------------
  logic [31:0]           ar_off, aw_off;
  logic                  ar_ok, aw_ok;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;

  assign ar_off = araddr - BASE_ADDR;
  assign aw_off = awaddr - BASE_ADDR;
  assign ar_ok  = ({1'b0, ar_off} < SPAN);
  assign aw_ok  = ({1'b0, aw_off} < SPAN);
  assign ar_idx = ar_off[DEPTH_LOG2+2:3];
  assign aw_idx = aw_off[DEPTH_LOG2+2:3];

  // ---------------------------------------------------------------------------
  // Wait-time selection, sampled at each handshake.
  // ---------------------------------------------------------------------------
  logic [4:0] rd_lat, wr_lat;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4, free-running.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign rd_lat = RD_BASE + {3'b000, lfsr[1:0]};
  assign wr_lat = WR_BASE + {3'b000, lfsr[1:0]};
`else
  assign rd_lat = RD_BASE;
  assign wr_lat = WR_BASE;
`endif

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [4:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_ok;
  logic                  ar_hs;
  logic                  r_sample;
  logic [DEPTH_LOG2-1:0] s_idx;
  logic                  s_ok;

  assign arready  = (r_state == R_IDLE) && !rst;
  assign ar_hs    = arready && arvalid;
  assign rvalid   = (r_state == R_RESP);
  assign rd_state = r_state;

  // Memory is sampled on the edge that moves the FSM into R_RESP. With a zero
  // wait that is the handshake edge itself, so the live address is used.
  assign r_sample = (ar_hs && (rd_lat == 5'd0)) ||
                    ((r_state == R_WAIT) && (r_cnt == 5'd0));
  assign s_idx    = (r_state == R_IDLE) ? ar_idx : r_idx;
  assign s_ok     = (r_state == R_IDLE) ? ar_ok  : r_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ok    <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      if (r_sample) begin
        rdata <= s_ok ? mem[s_idx] : 64'd0;
        rresp <= s_ok ? RESP_OKAY : RESP_SLVERR;
      end
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_idx <= ar_idx;
            r_ok  <= ar_ok;
            if (rd_lat == 5'd0) begin
              r_state <= R_RESP;
            end else begin
              r_state <= R_WAIT;
              r_cnt   <= rd_lat - 5'd1;
            end
          end
        end
        R_WAIT: begin
          if (r_cnt == 5'd0) begin
            r_state <= R_RESP;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state;
  logic [4:0]            w_cnt;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_ok;
  logic [63:0]           w_data_q;
  logic [7:0]            w_strb_q;
  logic                  aw_hs;
  logic                  commit;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic                  c_ok;
  logic [63:0]           c_data;
  logic [7:0]            c_strb;

  // AW and W are only ever taken together.
  assign aw_hs    = (w_state == W_IDLE) && awvalid && wvalid && !rst;
  assign awready  = aw_hs;
  assign wready   = aw_hs;
  assign bvalid   = (w_state == W_RESP);
  assign wr_state = w_state;

  // Commit happens on the edge that moves the FSM into W_RESP; a zero wait
  // commits straight from the bus on the handshake edge. Reset blocks it.
  assign commit = (aw_hs && (wr_lat == 5'd0)) ||
                  ((w_state == W_WAIT) && (w_cnt == 5'd0) && !rst);
  assign c_idx  = (w_state == W_IDLE) ? aw_idx : w_idx;
  assign c_ok   = (w_state == W_IDLE) ? aw_ok  : w_ok;
  assign c_data = (w_state == W_IDLE) ? wdata  : w_data_q;
  assign c_strb = (w_state == W_IDLE) ? wstrb  : w_strb_q;
  assign mem_we = commit && c_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state  <= W_IDLE;
      w_cnt    <= '0;
      w_idx    <= '0;
      w_ok     <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp    <= RESP_OKAY;
    end else begin
      if (commit) begin
        bresp <= c_ok ? RESP_OKAY : RESP_SLVERR;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx    <= aw_idx;
            w_ok     <= aw_ok;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
            if (wr_lat == 5'd0) begin
              w_state <= W_RESP;
            end else begin
              w_state <= W_WAIT;
              w_cnt   <= wr_lat - 5'd1;
            end
          end
        end
        W_WAIT: begin
          if (w_cnt == 5'd0) begin
            w_state <= W_RESP;
          end else begin
            w_cnt <= w_cnt - 5'd1;
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory array, byte-enabled, not reset. A read sampling the same word on
  // the same edge sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (c_strb[i]) begin
          mem[c_idx][8*i +: 8] <= c_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_sram_slave
//   Self-checking bench for axi_sram_slave with default parameters and the
//   random-delay option off: directed vector table, hand-written multi-cycle
//   sequences (read stall, AW without W, same-word read/write, reset during a
//   write) and a randomized phase checked against a behavioural memory model.
// -----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 1024;
  localparam int          LAT   = 3;   // handshake cycle to response cycle

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic        arvalid = 1'b0;
  logic [31:0] araddr  = '0;
  logic        arready;
  logic        rvalid;
  logic [1:0]  rresp;
  logic [63:0] rdata;
  logic        rready  = 1'b0;
  logic        awvalid = 1'b0;
  logic [31:0] awaddr  = '0;
  logic        awready;
  logic        wvalid  = 1'b0;
  logic [63:0] wdata   = '0;
  logic [7:0]  wstrb   = '0;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready  = 1'b0;
  logic [1:0]  rd_state;
  logic [1:0]  wr_state;

  axi_sram_slave dut (
    .clk      (clk),
    .rst      (rst),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .arready  (arready),
    .rvalid   (rvalid),
    .rresp    (rresp),
    .rdata    (rdata),
    .rready   (rready),
    .awvalid  (awvalid),
    .awaddr   (awaddr),
    .awready  (awready),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wready   (wready),
    .bvalid   (bvalid),
    .bresp    (bresp),
    .bready   (bready),
    .rd_state (rd_state),
    .wr_state (wr_state)
  );

  // scoreboard counters
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // behavioural reference model
  // ---------------------------------------------------------------------------
  logic [63:0] model_mem [WORDS];

  function automatic logic m_in_range(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return (off >= 0) && (off < 8 * WORDS);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    longint off;
    off = longint'({32'd0, a}) - longint'({32'd0, BASE});
    return int'(off / 8);
  endfunction

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic axi_write(input logic [31:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp,
                           output int lat);
    int n;
    n = 0;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    #1;
    while (!(awready && wready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) check("aw_accept_timeout", 64'(awready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    lat = 1;
    while (!bvalid && lat < 40) begin
      @(negedge clk); lat++;
    end
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [63:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr;
    #1;
    while (!arready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) check("ar_accept_timeout", 64'(arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    lat = 1;
    while (!rvalid && lat < 40) begin
      @(negedge clk); lat++;
    end
    data = rdata;
    resp = rresp;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, 32'h8000_0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'd0, 2'b00};
    vecs[1]  = '{1'b1, 32'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 2'b00};
    vecs[2]  = '{1'b0, 32'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'd0, 2'b00};
    vecs[4]  = '{1'b0, 32'h8000_000C, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 2'b00};
    vecs[6]  = '{1'b0, 32'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 2'b00};
    vecs[7]  = '{1'b0, 32'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 2'b10};
    vecs[8]  = '{1'b1, 32'h8000_2000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 64'd0, 2'b10};
    vecs[9]  = '{1'b0, 32'h8000_0000, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF, 2'b00};
    vecs[10] = '{1'b1, 32'h8000_1FF8, 64'h5A5A_5A5A_A5A5_A5A5, 8'hFF, 64'd0, 2'b00};
    vecs[11] = '{1'b0, 32'h8000_1FF8, 64'd0, 8'h00, 64'h5A5A_5A5A_A5A5_A5A5, 2'b00};
    vecs[12] = '{1'b0, 32'h8000_2000, 64'd0, 8'h00, 64'd0, 2'b10};

    // ---- reset state (valids held high to show readies stay low) ----
    rst = 1'b1;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready",  64'(wready),  64'd0);
    check("rst_rvalid",  64'(rvalid),  64'd0);
    check("rst_bvalid",  64'(bvalid),  64'd0);
    check("rst_rresp",   64'(rresp),   64'd0);
    check("rst_bresp",   64'(bresp),   64'd0);
    check("rst_rdata",   rdata,        64'd0);
    check("rst_rd_idle", 64'(rd_state), 64'd0);
    check("rst_wr_idle", 64'(wr_state), 64'd0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        check($sformatf("vec%0d_bresp", i), 64'(r), 64'(vecs[i].exp_resp));
        check($sformatf("vec%0d_blat", i), 64'(lat), 64'(LAT));
      end else begin
        axi_read(vecs[i].addr, d, r, lat);
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("vec%0d_rresp", i), 64'(r), 64'(vecs[i].exp_resp));
        check($sformatf("vec%0d_rlat", i), 64'(lat), 64'(LAT));
      end
    end

    // ---- read stall: rready low for 5 cycles, second AR pending ----
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h8000_0008; rready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    araddr = 32'h8000_0000;   // second request waits behind the first
    n = 1;
    while (!rvalid && n < 40) begin
      @(negedge clk); n++;
    end
    check("stall_lat", 64'(n), 64'(LAT));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_rvalid", k), 64'(rvalid), 64'd1);
      check($sformatf("stall%0d_rdata", k), rdata, 64'h1122_3344_BBBB_BBBB);
      check($sformatf("stall%0d_rresp", k), 64'(rresp), 64'd0);
      check($sformatf("stall%0d_arready", k), 64'(arready), 64'd0);
      if (k < 4) @(negedge clk);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("stall_release_rvalid", 64'(rvalid), 64'd0);
    check("stall_release_arready", 64'(arready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin
      @(negedge clk); n++;
    end
    check("stall_second_lat", 64'(n), 64'(LAT));
    check("stall_second_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;

    // ---- AW without W is not accepted ----
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8000_0018; wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("aw_only%0d_awready", k), 64'(awready), 64'd0);
      check($sformatf("aw_only%0d_wready", k), 64'(wready), 64'd0);
      @(negedge clk);
    end
    check("aw_only_bvalid", 64'(bvalid), 64'd0);
    awvalid = 1'b0;

    // ---- same-word read and write on the same edge ----
    axi_write(32'h8000_0010, 64'h1111_1111_1111_1111, 8'hFF, r, lat);
    check("coll_init_bresp", 64'(r), 64'd0);
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h8000_0010;
    awvalid = 1'b1; awaddr = 32'h8000_0010; wvalid = 1'b1;
    wdata = 64'h2222_2222_2222_2222; wstrb = 8'hFF;
    #1;
    check("coll_ready", {61'd0, arready, awready, wready}, 64'd7);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    n = 1;
    while (!(rvalid && bvalid) && n < 40) begin
      @(negedge clk); n++;
    end
    check("coll_lat", 64'(n), 64'(LAT));
    check("coll_old_rdata", rdata, 64'h1111_1111_1111_1111);
    check("coll_bresp", 64'(bresp), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h8000_0010, d, r, lat);
    check("coll_new_rdata", d, 64'h2222_2222_2222_2222);

    // ---- reset while a write waits: no commit, outputs cleared ----
    axi_write(32'h9000_0000, 64'h3333_3333_3333_3333, 8'hFF, r, lat);
    check("pre_rst_oor_bresp", 64'(r), 64'd2);
    axi_read(32'h8000_0010, d, r, lat);
    check("pre_rst_rdata", d, 64'h2222_2222_2222_2222);
    @(negedge clk);
    awvalid = 1'b1; awaddr = 32'h8000_0010; wvalid = 1'b1;
    wdata = 64'h4444_4444_4444_4444; wstrb = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("mid_wr_state_busy", 64'(wr_state != 2'd0), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wrst_arready", 64'(arready), 64'd0);
    check("wrst_awready", 64'(awready), 64'd0);
    check("wrst_wready",  64'(wready),  64'd0);
    check("wrst_rvalid",  64'(rvalid),  64'd0);
    check("wrst_bvalid",  64'(bvalid),  64'd0);
    check("wrst_rresp",   64'(rresp),   64'd0);
    check("wrst_bresp",   64'(bresp),   64'd0);
    check("wrst_rdata",   rdata,        64'd0);
    rst = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("wrst_no_bvalid%0d", k), 64'(bvalid), 64'd0);
    end
    bready = 1'b0;
    axi_read(32'h8000_0010, d, r, lat);
    check("wrst_no_commit", d, 64'h2222_2222_2222_2222);

    // ---- randomized phase against the reference model ----
    for (int w = 0; w < 16; w++) begin
      logic [31:0] a;
      logic [63:0] v;
      a = BASE + 32'(w * 8);
      v = {$urandom, $urandom};
      axi_write(a, v, 8'hFF, r, lat);
      model_mem[w] = v;
      check($sformatf("rinit%0d_bresp", w), 64'(r), 64'd0);
    end
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic [63:0] v;
      logic [7:0]  s;
      logic [63:0] exp_d;
      logic [1:0]  exp_r;
      if ($urandom_range(0, 99) < 85)
        a = BASE + 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 0)
        a = BASE - 32'($urandom_range(1, 100) * 8);
      else
        a = BASE + 32'(8 * WORDS) + 32'($urandom_range(0, 100) * 8);
      if ($urandom_range(0, 1) == 0) begin
        v = {$urandom, $urandom};
        s = 8'($urandom_range(0, 255));
        axi_write(a, v, s, r, lat);
        if (m_in_range(a)) begin
          for (int b = 0; b < 8; b++)
            if (s[b]) model_mem[m_index(a)][8*b +: 8] = v[8*b +: 8];
          exp_r = 2'b00;
        end else begin
          exp_r = 2'b10;
        end
        check($sformatf("rnd%0d_bresp", t), 64'(r), 64'(exp_r));
        check($sformatf("rnd%0d_blat", t), 64'(lat), 64'(LAT));
      end else begin
        axi_read(a, d, r, lat);
        if (m_in_range(a)) begin
          exp_d = model_mem[m_index(a)];
          exp_r = 2'b00;
        end else begin
          exp_d = 64'd0;
          exp_r = 2'b10;
        end
        check($sformatf("rnd%0d_rdata", t), d, exp_d);
        check($sformatf("rnd%0d_rresp", t), 64'(r), 64'(exp_r));
        check($sformatf("rnd%0d_rlat", t), 64'(lat), 64'(LAT));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
